// File: rtl/circulant_transpose_buffer.sv
`default_nettype none
// ============================================================================
// Module   : circulant_transpose_buffer
// Summary  : N x N ping-pong transpose buffer. Rows are stored circulantly
//            across N column banks, so a full column or row reads out per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module circulant_transpose_buffer #(
    parameter int DATA_W = 8,
    parameter int N      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [N*DATA_W-1:0]  s_data,
    input  logic                 s_transpose,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [N*DATA_W-1:0]  m_data,
    output logic [$clog2(N)-1:0] m_index,
    output logic                 m_last
);

    localparam int              c_aw       = $clog2(N);
    localparam logic [c_aw-1:0] c_last     = c_aw'(N - 1);
    localparam logic [1:0]      c_empty    = 2'd0;
    localparam logic [1:0]      c_filling  = 2'd1;
    localparam logic [1:0]      c_full     = 2'd2;
    localparam logic [1:0]      c_draining = 2'd3;

    logic [1:0]          r_pg_state     [2];
    logic [1:0]          w_pg_state_nxt [2];
    logic [1:0]          r_pg_mode;
    logic                r_wr_page;
    logic [c_aw-1:0]     r_wr_row;
    logic                r_iss_page;
    logic [c_aw-1:0]     r_iss_idx;
    logic                r_s1_valid;
    logic                r_s1_page;
    logic [c_aw-1:0]     r_s1_idx;
    logic                r_m_page;
    logic [N*DATA_W-1:0] w_bank_q;
    logic [N*DATA_W-1:0] w_rot;
    logic [1:0]          w_fill_state;
    logic [1:0]          w_iss_state;
    logic                w_wr_en;
    logic                w_iss_ok;
    logic                w_iss;
    logic                w_iss_mode;
    logic                w_s1_open;
    logic                w_s2_open;
    logic                w_free;

    always_comb begin
        w_fill_state = r_pg_state[r_wr_page];
        w_iss_state  = r_pg_state[r_iss_page];
        w_iss_mode   = r_pg_mode[r_iss_page];
        s_ready      = !rst && ((w_fill_state == c_empty) || (w_fill_state == c_filling));
        w_wr_en      = s_valid && s_ready;
        // Vector 0 only starts a page that is FULL; a DRAINING page at index 0 is
        // one whose reads are all issued but whose tail is still in the pipeline.
        w_iss_ok     = (w_iss_state == c_full) ||
                       ((w_iss_state == c_draining) && (r_iss_idx != '0));
        w_s2_open    = !m_valid || m_ready;
        w_s1_open    = !r_s1_valid || w_s2_open;
        w_iss        = w_iss_ok && w_s1_open;
        w_free       = m_valid && m_ready && m_last;
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_pg_state_nxt[p] = r_pg_state[p];
            if (w_wr_en && (r_wr_page == 1'(p))) begin
                if (r_wr_row == c_last) begin
                    w_pg_state_nxt[p] = c_full;
                end else if (r_wr_row == '0) begin
                    w_pg_state_nxt[p] = c_filling;
                end
            end
            if (w_iss && (r_iss_page == 1'(p)) && (r_iss_idx == '0)) begin
                w_pg_state_nxt[p] = c_draining;
            end
            if (w_free && (r_m_page == 1'(p))) begin
                w_pg_state_nxt[p] = c_empty;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pg_state[0] <= c_empty;
            r_pg_state[1] <= c_empty;
            r_pg_mode     <= '0;
            r_wr_page     <= 1'b0;
            r_wr_row      <= '0;
            r_iss_page    <= 1'b0;
            r_iss_idx     <= '0;
            r_s1_valid    <= 1'b0;
            r_s1_page     <= 1'b0;
            r_s1_idx      <= '0;
            r_m_page      <= 1'b0;
            m_valid       <= 1'b0;
            m_data        <= '0;
            m_index       <= '0;
            m_last        <= 1'b0;
        end else begin
            r_pg_state[0] <= w_pg_state_nxt[0];
            r_pg_state[1] <= w_pg_state_nxt[1];
            if (w_wr_en) begin
                r_wr_row <= r_wr_row + 1'b1;
                if (r_wr_row == '0) begin
                    r_pg_mode[r_wr_page] <= s_transpose;
                end
                if (r_wr_row == c_last) begin
                    r_wr_page <= ~r_wr_page;
                end
            end
            if (w_iss) begin
                r_iss_idx <= r_iss_idx + 1'b1;
                if (r_iss_idx == c_last) begin
                    r_iss_page <= ~r_iss_page;
                end
            end
            // Stage 1 doubles as the skid slot: bank outputs only move on issue.
            if (w_s1_open) begin
                r_s1_valid <= w_iss;
                r_s1_idx   <= r_iss_idx;
                r_s1_page  <= r_iss_page;
            end
            if (w_s2_open) begin
                m_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    m_data   <= w_rot;
                    m_index  <= r_s1_idx;
                    m_last   <= (r_s1_idx == c_last);
                    r_m_page <= r_s1_page;
                end
            end
        end
    end

    for (genvar b = 0; b < N; b++) begin : g_bank
        localparam logic [c_aw-1:0] c_bank = c_aw'(b);
        logic [DATA_W-1:0] r_mem [2*N];
        logic [DATA_W-1:0] r_q;
        logic [c_aw-1:0]   w_lane;
        logic [c_aw-1:0]   w_rd_row;

        always_comb begin
            w_lane   = c_bank - r_wr_row;
            w_rd_row = w_iss_mode ? (c_bank - r_iss_idx) : r_iss_idx;
        end

        always_ff @(posedge clk) begin
            if (w_wr_en) begin
                r_mem[{r_wr_page, r_wr_row}] <= s_data[w_lane*DATA_W +: DATA_W];
            end
            if (w_iss) begin
                r_q <= r_mem[{r_iss_page, w_rd_row}];
            end
        end

        assign w_bank_q[b*DATA_W +: DATA_W] = r_q;
    end

    // Both modes place bank (lane + index) mod N on each output lane.
    for (genvar i = 0; i < N; i++) begin : g_rot
        logic [c_aw-1:0] w_src;
        assign w_src = c_aw'(i) + r_s1_idx;
        assign w_rot[i*DATA_W +: DATA_W] = w_bank_q[w_src*DATA_W +: DATA_W];
    end

endmodule
`default_nettype wire

// File: tb/tb_circulant_transpose_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_circulant_transpose_buffer
// Summary  : Scoreboard bench for the transpose buffer at N=4/8 and N=8/16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_circulant_transpose_buffer;

    typedef struct {
        logic [127:0] data;
        int           idx;
        bit           last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         s_valid4, s_ready4, s_tr4, m_valid4, m_ready4, m_last4;
    logic [31:0]  s_data4, m_data4;
    logic [1:0]   m_index4;
    logic         s_valid8, s_ready8, s_tr8, m_valid8, m_ready8, m_last8;
    logic [127:0] s_data8, m_data8;
    logic [2:0]   m_index8;

    circulant_transpose_buffer #(.DATA_W(8), .N(4)) dut4 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4), .s_transpose(s_tr4),
        .m_valid(m_valid4), .m_ready(m_ready4), .m_data(m_data4),
        .m_index(m_index4), .m_last(m_last4)
    );

    circulant_transpose_buffer #(.DATA_W(16), .N(8)) dut8 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid8), .s_ready(s_ready8), .s_data(s_data8), .s_transpose(s_tr8),
        .m_valid(m_valid8), .m_ready(m_ready8), .m_data(m_data8),
        .m_index(m_index8), .m_last(m_last8)
    );

    int          total = 0, bad = 0, cyc = 0;
    int          rows4 = 0, pops4 = 0, rows8 = 0, pops8 = 0;
    int          mark4 = -1, pops_at_mark4 = 0;
    int          acc8 [32];
    int          pop8 [32];
    bit          rnd4 = 1'b0, t3_done = 1'b0;
    exp_t        q4[$], q8[$];
    exp_t        e4, e8;
    logic [7:0]  m4 [4][4];
    logic [15:0] m8 [8][8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- N=4 driver / monitor ----------------
    task automatic put_row4(input logic [31:0] row, input bit tr);
        int n = 0;
        s_valid4 = 1'b1; s_data4 = row; s_tr4 = tr;
        @(negedge clk);
        while (!s_ready4 && n < 2000) begin @(negedge clk); n++; end
        if (!s_ready4) check("s_ready4_wait", s_ready4, 1'b1);
        @(posedge clk); #1;
        rows4++;
        if (rows4 == mark4) pops_at_mark4 = pops4;
        s_valid4 = 1'b0; s_data4 = $urandom; s_tr4 = 1'($urandom_range(0, 1));
    endtask

    task automatic send_matrix4(input bit tr0, input bit trr);
        exp_t        e;
        logic [31:0] row;
        for (int v = 0; v < 4; v++) begin
            e.data = '0;
            for (int l = 0; l < 4; l++) e.data[l*8 +: 8] = tr0 ? m4[l][v] : m4[v][l];
            e.idx = v; e.last = (v == 3);
            q4.push_back(e);
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) row[c*8 +: 8] = m4[r][c];
            put_row4(row, (r == 0) ? tr0 : trr);
        end
    endtask

    task automatic wait_drain4();
        int n = 0;
        while (q4.size() != 0 && n < 5000) begin @(posedge clk); n++; end
        check("drain4_left", q4.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    logic [127:0] h4_data;
    logic [1:0]   h4_idx;
    logic         h4_last;
    bit           h4_stall = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            h4_stall = 1'b0;
        end else begin
            if (h4_stall) begin
                check("hold4_valid", m_valid4, 1'b1);
                check("hold4_data", m_data4, h4_data);
                check("hold4_index", m_index4, h4_idx);
                check("hold4_last", m_last4, h4_last);
            end
            h4_stall = m_valid4 && !m_ready4;
            h4_data = m_data4; h4_idx = m_index4; h4_last = m_last4;
            if (m_valid4 && m_ready4) begin
                if (q4.size() == 0) begin
                    check("extra4_valid", m_valid4, 1'b0);
                end else begin
                    e4 = q4.pop_front();
                    check("m4_data", m_data4, e4.data);
                    check("m4_index", m_index4, e4.idx);
                    check("m4_last", m_last4, e4.last);
                    pops4++;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rnd4) m_ready4 = 1'($urandom_range(0, 1));
    end

    // ---------------- N=8 driver / monitor ----------------
    task automatic put_row8(input logic [127:0] row, input bit tr);
        int n = 0;
        s_valid8 = 1'b1; s_data8 = row; s_tr8 = tr;
        @(negedge clk);
        while (!s_ready8 && n < 2000) begin @(negedge clk); n++; end
        if (!s_ready8) check("s_ready8_wait", s_ready8, 1'b1);
        @(posedge clk); #1;
        if (rows8 < 32) acc8[rows8] = cyc;
        rows8++;
    endtask

    task automatic send_matrix8(input bit tr0);
        exp_t         e;
        logic [127:0] row;
        for (int v = 0; v < 8; v++) begin
            e.data = '0;
            for (int l = 0; l < 8; l++) e.data[l*16 +: 16] = tr0 ? m8[l][v] : m8[v][l];
            e.idx = v; e.last = (v == 7);
            q8.push_back(e);
        end
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) row[c*16 +: 16] = m8[r][c];
            put_row8(row, (r == 0) ? tr0 : ~tr0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && m_valid8 && m_ready8) begin
            if (q8.size() == 0) begin
                check("extra8_valid", m_valid8, 1'b0);
            end else begin
                e8 = q8.pop_front();
                check("m8_data", m_data8, e8.data);
                check("m8_index", m_index8, e8.idx);
                check("m8_last", m_last8, e8.last);
                if (pops8 < 32) pop8[pops8] = cyc;
                pops8++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, pb, base;
        rst = 1'b1;
        s_valid4 = 0; s_data4 = '0; s_tr4 = 0; m_ready4 = 0;
        s_valid8 = 0; s_data8 = '0; s_tr8 = 0; m_ready8 = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", m_valid4, 1'b0);
        check("rst_m_data", m_data4, 32'h0);
        check("rst_m_index", m_index4, 2'd0);
        check("rst_m_last", m_last4, 1'b0);
        check("rst_s_ready", s_ready4, 1'b0);
        check("rst_s_ready8", s_ready8, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", s_ready4, 1'b1);
        check("post_rst_s_ready8", s_ready8, 1'b1);

        // T1: transpose with latency check
        @(posedge clk); #1;
        m_ready4 = 1'b1;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) m4[r][c] = 8'(4*r + c);
        send_matrix4(1'b1, 1'b1);
        @(negedge clk); check("t1_lat_c0", m_valid4, 1'b0);
        @(negedge clk); check("t1_lat_c1", m_valid4, 1'b0);
        @(negedge clk); check("t1_lat_c2", m_valid4, 1'b1);
        check("t1_first_vec", m_data4, 32'h0C080400);
        wait_drain4();

        // T2: bypass selected by row 0 only
        send_matrix4(1'b0, 1'b1);
        wait_drain4();

        // T3: three matrices against a stalled consumer
        pb = pops4; base = rows4; mark4 = base + 9; t3_done = 1'b0;
        m_ready4 = 1'b0;
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) m4[r][c] = 8'($urandom);
                    send_matrix4((k % 2) == 0, 1'b0);
                end
                t3_done = 1'b1;
            end
        join_none
        n = 0;
        while (rows4 < base + 8 && n < 500) begin @(posedge clk); #1; n++; end
        check("t3_rows_before_stall", rows4, base + 8);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("t3_s_ready_low", s_ready4, 1'b0);
        check("t3_rows_held", rows4, base + 8);
        @(posedge clk); #1 m_ready4 = 1'b1;
        n = 0;
        while (!t3_done && n < 500) begin @(posedge clk); #1; n++; end
        check("t3_sender_done", t3_done, 1'b1);
        wait_drain4();
        check("t3_vectors", pops4 - pb, 12);
        check("t3_drain_before_refill", (pops_at_mark4 - pb) >= 4, 1'b1);

        // T4: random matrices, random modes, random backpressure
        rnd4 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) m4[r][c] = 8'($urandom);
            send_matrix4(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        wait_drain4();
        rnd4 = 1'b0; m_ready4 = 1'b1;

        // T5: reset mid-drain with the next matrix half written
        m_ready4 = 1'b0;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) m4[r][c] = 8'(8'h40 + 4*r + c);
        send_matrix4(1'b1, 1'b1);
        put_row4(32'hDEADBEEF, 1'b0);
        put_row4(32'h12345678, 1'b0);
        pb = pops4; m_ready4 = 1'b1;
        n = 0;
        while (pops4 < pb + 2 && n < 100) begin @(posedge clk); #1; n++; end
        check("t5_two_drained", pops4 - pb, 2);
        m_ready4 = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("t5_s_ready_in_rst", s_ready4, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; q4.delete();
        @(negedge clk);
        check("t5_m_valid_after_rst", m_valid4, 1'b0);
        check("t5_m_data_after_rst", m_data4, 32'h0);
        check("t5_s_ready_after_rst", s_ready4, 1'b1);
        @(posedge clk); #1 m_ready4 = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) m4[r][c] = 8'(8'h80 + 4*r + c);
        send_matrix4(1'b1, 1'b0);
        wait_drain4();

        // T6: N=8, DATA_W=16 continuous streaming
        m_ready8 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    m8[r][c] = (k == 0) ? 16'(8*r + c) : 16'($urandom);
            send_matrix8(1'b1);
        end
        s_valid8 = 1'b0;
        n = 0;
        while (q8.size() != 0 && n < 2000) begin @(posedge clk); n++; end
        check("drain8_left", q8.size(), 0);
        check("t6_vectors", pops8, 24);
        check("t6_rows_back_to_back", acc8[15] - acc8[0], 15);
        check("t6_vecs_back_to_back", pop8[15] - pop8[0], 15);
        check("t6_first_latency", pop8[0] - acc8[7], 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
